// File: rtl/instr_encoder.sv
// instr_encoder: packs decoded MIPS instruction fields into 32-bit words,
// buffers them in a DEPTH-entry FIFO and writes them to instruction memory
// at auto-incrementing word addresses.
// Optional feature macro: ENCODER_ILLEGAL_TRAP_EN
//   defined   -> mnemonic 15 is dropped on accept and sets the sticky err flag
//   undefined -> mnemonic 15 encodes as a NOP (32'h0) and err stays 0
module instr_encoder #(
    parameter int DEPTH      = 4,
    parameter int ADDR_WIDTH = 8
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [3:0]            in_mnem,
    input  logic [4:0]            in_rs,
    input  logic [4:0]            in_rt,
    input  logic [4:0]            in_rd,
    input  logic [4:0]            in_shamt,
    input  logic [15:0]           in_imm16,
    input  logic [25:0]           in_addr26,
    input  logic                  load_base,
    input  logic [ADDR_WIDTH-1:0] base_addr,
    output logic                  mem_we,
    input  logic                  mem_ready,
    output logic [ADDR_WIDTH-1:0] mem_addr,
    output logic [31:0]           mem_data,
    output logic [ADDR_WIDTH:0]   written,
    output logic                  err
);

    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    // Mnemonic codes
    localparam logic [3:0] M_ADD  = 4'd0;
    localparam logic [3:0] M_ADDI = 4'd1;
    localparam logic [3:0] M_SLL  = 4'd2;
    localparam logic [3:0] M_SLT  = 4'd3;
    localparam logic [3:0] M_AND  = 4'd4;
    localparam logic [3:0] M_ANDI = 4'd5;
    localparam logic [3:0] M_ORI  = 4'd6;
    localparam logic [3:0] M_BNE  = 4'd7;
    localparam logic [3:0] M_SW   = 4'd8;
    localparam logic [3:0] M_LW   = 4'd9;
    localparam logic [3:0] M_J    = 4'd10;
    localparam logic [3:0] M_JAL  = 4'd11;
    localparam logic [3:0] M_OR   = 4'd12;
    localparam logic [3:0] M_SUB  = 4'd13;
    localparam logic [3:0] M_NOR  = 4'd14;
    localparam logic [3:0] M_ILL  = 4'd15;

    // R-type word; SLL keeps shamt and zeroes rs, other R-types zero shamt.
    function automatic logic [31:0] enc_r(input logic [4:0] rs, input logic [4:0] rt,
                                          input logic [4:0] rd, input logic [4:0] sh,
                                          input logic [5:0] funct, input logic is_shift);
        logic [4:0] rs_f;
        logic [4:0] sh_f;
        rs_f = is_shift ? 5'd0 : rs;
        sh_f = is_shift ? sh : 5'd0;
        return {6'd0, rs_f, rt, rd, sh_f, funct};
    endfunction

    function automatic logic [31:0] enc_i(input logic [5:0] op, input logic [4:0] rs,
                                          input logic [4:0] rt, input logic [15:0] imm);
        return {op, rs, rt, imm};
    endfunction

    function automatic logic [31:0] enc_j(input logic [5:0] op, input logic [25:0] target);
        return {op, target};
    endfunction

    // Full encoder; the illegal code falls through to the NOP word.
    function automatic logic [31:0] encode(input logic [3:0] mnem, input logic [4:0] rs,
                                           input logic [4:0] rt, input logic [4:0] rd,
                                           input logic [4:0] sh, input logic [15:0] imm,
                                           input logic [25:0] target);
        logic [31:0] w;
        w = 32'h0000_0000;
        case (mnem)
            M_ADD:  w = enc_r(rs, rt, rd, sh, 6'h20, 1'b0);
            M_SLL:  w = enc_r(rs, rt, rd, sh, 6'h00, 1'b1);
            M_SLT:  w = enc_r(rs, rt, rd, sh, 6'h2A, 1'b0);
            M_AND:  w = enc_r(rs, rt, rd, sh, 6'h24, 1'b0);
            M_OR:   w = enc_r(rs, rt, rd, sh, 6'h25, 1'b0);
            M_SUB:  w = enc_r(rs, rt, rd, sh, 6'h22, 1'b0);
            M_NOR:  w = enc_r(rs, rt, rd, sh, 6'h27, 1'b0);
            M_ADDI: w = enc_i(6'h08, rs, rt, imm);
            M_ANDI: w = enc_i(6'h0C, rs, rt, imm);
            M_ORI:  w = enc_i(6'h0D, rs, rt, imm);
            M_BNE:  w = enc_i(6'h05, rs, rt, imm);
            M_SW:   w = enc_i(6'h2B, rs, rt, imm);
            M_LW:   w = enc_i(6'h23, rs, rt, imm);
            M_J:    w = enc_j(6'h02, target);
            M_JAL:  w = enc_j(6'h03, target);
            default: w = 32'h0000_0000;
        endcase
        return w;
    endfunction

    logic [31:0]           fifo_q [DEPTH];
    logic [PTR_W-1:0]      wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0]      rd_ptr_q, rd_ptr_d;
    logic [PTR_W:0]        count_q, count_d;
    logic [ADDR_WIDTH-1:0] addr_q, addr_d;
    logic [ADDR_WIDTH:0]   written_q, written_d;
    logic                  err_q, err_d;

    logic        full;
    logic        empty;
    logic        accept;
    logic        drop;
    logic        push;
    logic        pop;
    logic [31:0] enc_word;

    assign full   = (count_q == (PTR_W+1)'(DEPTH));
    assign empty  = (count_q == '0);
    assign accept = in_valid && in_ready;

`ifdef ENCODER_ILLEGAL_TRAP_EN
    assign drop = (in_mnem == M_ILL);
`else
    assign drop = 1'b0;
`endif

    assign push     = accept && !drop;
    assign pop      = mem_we && mem_ready;
    assign enc_word = encode(in_mnem, in_rs, in_rt, in_rd, in_shamt, in_imm16, in_addr26);

    // Outputs come straight from registered state, so no in_*/mem_ready path reaches them.
    assign in_ready = !full;
    assign mem_we   = !empty;
    assign mem_data = empty ? 32'h0000_0000 : fifo_q[rd_ptr_q];
    assign mem_addr = addr_q;
    assign written  = written_q;
    assign err      = err_q;

    // Next-state for FIFO pointers, occupancy, address counter, commit count and error flag.
    always_comb begin
        wr_ptr_d  = wr_ptr_q;
        rd_ptr_d  = rd_ptr_q;
        count_d   = count_q;
        addr_d    = addr_q;
        written_d = written_q;
        err_d     = err_q;

        if (push) begin
            wr_ptr_d = wr_ptr_q + PTR_W'(1);
        end
        if (pop) begin
            rd_ptr_d  = rd_ptr_q + PTR_W'(1);
            written_d = written_q + (ADDR_WIDTH+1)'(1);
        end
        case ({push, pop})
            2'b10:   count_d = count_q + (PTR_W+1)'(1);
            2'b01:   count_d = count_q - (PTR_W+1)'(1);
            default: count_d = count_q;
        endcase

        // A base load wins over the commit increment; the pop still happens.
        if (load_base) begin
            addr_d = base_addr;
        end else if (pop) begin
            addr_d = addr_q + ADDR_WIDTH'(1);
        end

`ifdef ENCODER_ILLEGAL_TRAP_EN
        if (accept && drop) begin
            err_d = 1'b1;
        end
`endif
    end

    // Control state register with synchronous reset; reset also flushes the FIFO.
    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr_q  <= '0;
            rd_ptr_q  <= '0;
            count_q   <= '0;
            addr_q    <= '0;
            written_q <= '0;
            err_q     <= 1'b0;
        end else begin
            wr_ptr_q  <= wr_ptr_d;
            rd_ptr_q  <= rd_ptr_d;
            count_q   <= count_d;
            addr_q    <= addr_d;
            written_q <= written_d;
            err_q     <= err_d;
        end
    end

    // FIFO storage; data only, validity is tracked by the pointers and count.
    always_ff @(posedge clk) begin
        if (push) begin
            fifo_q[wr_ptr_q] <= enc_word;
        end
    end

endmodule
